// File: rtl/adder_tree_acc_pipe.sv
// rtl/adder_tree_acc_pipe.sv - pipelined signed adder tree feeding a multi-beat accumulator
// Optional saturating accumulator: define ADDER_TREE_ACC_SAT_EN.
module adder_tree_acc_pipe #(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 18,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_IN*IN_W-1:0]   in_data,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     busy
);
    localparam int L = $clog2(NUM_IN);

    // Tag index k travels with data stage k; stage 0 is the registered input beat.
    logic [L:0] tag_v_q, tag_v_d;
    logic [L:0] tag_f_q, tag_f_d;
    logic [L:0] tag_l_q, tag_l_d;

    always_comb begin
        tag_v_d = {tag_v_q[L-1:0], in_valid};
        tag_f_d = {tag_f_q[L-1:0], in_valid & in_first};
        tag_l_d = {tag_l_q[L-1:0], in_valid & in_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
            tag_f_q <= '0;
            tag_l_q <= '0;
        end else begin
            tag_v_q <= tag_v_d;
            tag_f_q <= tag_f_d;
            tag_l_q <= tag_l_d;
        end
    end

    for (genvar k = 0; k <= L; k++) begin : g_stage
        localparam int W = IN_W + k;
        localparam int N = NUM_IN >> k;
        logic signed [W-1:0] sum_q [N];
        logic signed [W-1:0] sum_d [N];

        if (k == 0) begin : g_in
            always_comb begin
                for (int i = 0; i < N; i++)
                    sum_d[i] = in_valid ? $signed(in_data[i*IN_W +: IN_W]) : '0;
            end
        end else begin : g_add
            // Each pair is widened by one bit before adding, so no stage can overflow.
            always_comb begin
                for (int i = 0; i < N; i++)
                    sum_d[i] = tag_v_q[k-1]
                             ? W'(g_stage[k-1].sum_q[2*i]) + W'(g_stage[k-1].sum_q[2*i+1])
                             : '0;
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < N; i++)
                sum_q[i] <= rst ? '0 : sum_d[i];
        end
    end

    logic                    acc_v, acc_f, acc_l;
    logic signed [ACC_W-1:0] tree_ext;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_new;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    assign acc_v    = tag_v_q[L];
    assign acc_f    = tag_f_q[L];
    assign acc_l    = tag_l_q[L];
    assign tree_ext = ACC_W'(g_stage[L].sum_q[0]);

`ifdef ADDER_TREE_ACC_SAT_EN
    logic signed [ACC_W:0] acc_guard;
    logic                  sat_q, sat_d, sat_new;
    logic                  out_sat_q, out_sat_d;
    assign out_sat = out_sat_q;
`else
    assign out_sat = 1'b0;
`endif

    always_comb begin
        acc_d       = acc_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        acc_base    = acc_f ? '0 : acc_q;
`ifdef ADDER_TREE_ACC_SAT_EN
        sat_d       = sat_q;
        out_sat_d   = 1'b0;
        sat_new     = acc_f ? 1'b0 : sat_q;
        acc_guard   = (ACC_W+1)'(acc_base) + (ACC_W+1)'(tree_ext);
        // Guard bit disagreeing with the sign bit means the true sum left the ACC_W range.
        if (acc_guard[ACC_W] != acc_guard[ACC_W-1]) begin
            acc_new = acc_guard[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            sat_new = 1'b1;
        end else begin
            acc_new = acc_guard[ACC_W-1:0];
        end
`else
        acc_new     = acc_base + tree_ext;
`endif
        if (acc_v) begin
            if (acc_l) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_new;
                acc_d       = '0;
                busy_d      = 1'b0;
`ifdef ADDER_TREE_ACC_SAT_EN
                sat_d       = 1'b0;
                out_sat_d   = sat_new;
`endif
            end else begin
                acc_d       = acc_new;
                busy_d      = busy_q | acc_f;
`ifdef ADDER_TREE_ACC_SAT_EN
                sat_d       = sat_new;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADDER_TREE_ACC_SAT_EN
            sat_q       <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ADDER_TREE_ACC_SAT_EN
            sat_q       <= sat_d;
            out_sat_q   <= out_sat_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_adder_tree_acc_pipe.sv
// tb/tb_adder_tree_acc_pipe.sv - directed bench for adder_tree_acc_pipe (NUM_IN=8, IN_W=18, ACC_W=24)
module tb_adder_tree_acc_pipe;
    localparam int NUM_IN = 8;
    localparam int IN_W   = 18;
    localparam int ACC_W  = 24;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [NUM_IN*IN_W-1:0]  in_data;
    logic                    in_first;
    logic                    in_last;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sat;
    logic                    busy;

    adder_tree_acc_pipe #(.NUM_IN(NUM_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .out_valid(out_valid),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int edges  = 0;
    int q_data[$];
    int q_sat[$];
    int q_edge[$];
    bit busy_hist[4096];

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        busy_hist[edges % 4096] = busy;
        if (out_valid) begin
            q_data.push_back(int'(out_data));
            q_sat.push_back(int'(out_sat));
            q_edge.push_back(edges);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input int v, input bit f, input bit l, input bit vld, output int e);
        @(negedge clk);
        in_valid = vld;
        in_first = f;
        in_last  = l;
        for (int i = 0; i < NUM_IN; i++) in_data[i*IN_W +: IN_W] = IN_W'(v);
        e = edges + 1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sat.delete();
        q_edge.delete();
    endtask

    int e0, e1, e2;
    int exp_ovf, exp_ovf_sat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2);

        // 1: single beat of ones, latency 4 edges
        clear_q();
        beat(1, 1, 1, 1, e0);
        idle(7);
        check("t1_count", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("t1_data", q_data[0], 8);
            check("t1_edge", q_edge[0], e0 + 4);
        end
        check("t1_busy_after", busy, 0);

        // 2: most negative operands
        clear_q();
        beat(-131072, 1, 1, 1, e0);
        idle(7);
        check("t2_count", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("t2_data", q_data[0], -1048576);
            check("t2_sat", q_sat[0], 0);
        end

        // 3: multi-beat with a bubble carrying stray first/last
        clear_q();
        beat(1000, 1, 0, 1, e0);
        beat(999, 1, 1, 0, e1);
        beat(2000, 0, 0, 1, e1);
        beat(-500, 0, 1, 1, e2);
        idle(7);
        check("t3_count", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("t3_data", q_data[0], 20000);
            check("t3_edge", q_edge[0], e2 + 4);
        end
        check("t3_busy_pre", busy_hist[(e0 + 3) % 4096], 0);
        check("t3_busy_open", busy_hist[(e0 + 4) % 4096], 1);
        check("t3_busy_mid", busy_hist[(e0 + 6) % 4096], 1);
        check("t3_busy_close", busy_hist[(e2 + 4) % 4096], 0);

        // 4: accumulator overflow across ten beats
        clear_q();
        for (int b = 0; b < 10; b++) beat(131071, b == 0, b == 9, 1, e0);
        idle(7);
`ifdef ADDER_TREE_ACC_SAT_EN
        exp_ovf = 8388607; exp_ovf_sat = 1;
`else
        exp_ovf = -6291536; exp_ovf_sat = 0;
`endif
        check("t4_count", q_data.size(), 1);
        if (q_data.size() == 1) begin
            check("t4_data", q_data[0], exp_ovf);
            check("t4_sat", q_sat[0], exp_ovf_sat);
        end

        // 5: reset drops in-flight beats
        clear_q();
        beat(5, 1, 0, 1, e0);
        beat(5, 0, 0, 1, e0);
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy_rst", busy, 0);
        idle(6);
        check("t5_no_out", q_data.size(), 0);
        beat(3, 1, 1, 1, e0);
        idle(7);
        check("t5_count", q_data.size(), 1);
        if (q_data.size() == 1) check("t5_data", q_data[0], 24);

        // 6: back-to-back single-beat results
        clear_q();
        beat(1, 1, 1, 1, e0);
        beat(2, 1, 1, 1, e1);
        idle(7);
        check("t6_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("t6_data0", q_data[0], 8);
            check("t6_data1", q_data[1], 16);
            check("t6_edge0", q_edge[0], e0 + 4);
            check("t6_edge1", q_edge[1], e0 + 5);
        end

        // 7: implicit open, then first discarding an open partial
        clear_q();
        beat(10, 0, 1, 1, e0);
        beat(7, 1, 0, 1, e1);
        beat(-3, 1, 1, 1, e2);
        idle(7);
        check("t7_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check("t7_implicit", q_data[0], 80);
            check("t7_discard", q_data[1], -24);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
